// File: rtl/ysyx_23060286_alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: op codes, branch
// funct3 codes and arbiter state encoding.
package ysyx_23060286_alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_SRA   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_XOR   = 4'd8;
    localparam logic [3:0] ALU_PASSB = 4'd9;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } alu_arb_st_e;

endpackage

// File: rtl/ysyx_23060286_Alu.sv
// Combinational 32-bit ALU producing both the datapath result and the
// branch-condition flag selected by funct3.
module ysyx_23060286_Alu
    import ysyx_23060286_alu_pkg::*;
(
    input  logic [31:0] i_srca,
    input  logic [31:0] i_srcb,
    input  logic [3:0]  i_op,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic [4:0] w_shamt;
    logic       w_slt;
    logic       w_sltu;

    always_comb begin
        w_shamt = i_srcb[4:0];
        w_slt   = $signed(i_srca) < $signed(i_srcb);
        w_sltu  = i_srca < i_srcb;
    end

    always_comb begin
        o_result = 32'hFFFF_FFFF;
        case (i_op)
            ALU_ADD:   o_result = i_srca + i_srcb;
            ALU_SUB:   o_result = i_srca - i_srcb;
            ALU_AND:   o_result = i_srca & i_srcb;
            ALU_OR:    o_result = i_srca | i_srcb;
            ALU_SRA:   o_result = $unsigned($signed(i_srca) >>> w_shamt);
            ALU_SLT:   o_result = {31'd0, w_slt};
            ALU_SRL:   o_result = i_srca >> w_shamt;
            ALU_SLL:   o_result = i_srca << w_shamt;
            ALU_XOR:   o_result = i_srca ^ i_srcb;
            ALU_PASSB: o_result = i_srcb;
            default:   o_result = 32'hFFFF_FFFF;
        endcase
    end

    // Equality codes look at the result; compare codes look at the operands.
    always_comb begin
        o_zero = 1'b0;
        case (i_f3)
            F3_BEQ:  o_zero = (o_result == 32'd0);
            F3_BNE:  o_zero = (o_result != 32'd0);
            F3_BLT:  o_zero = w_slt;
            F3_BGE:  o_zero = !w_slt;
            F3_BLTU: o_zero = w_sltu;
            F3_BGEU: o_zero = !w_sltu;
            default: o_zero = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060286_alu_arb.sv
// Two-port round-robin arbiter sharing one ALU between the execute stage
// (port 0) and the branch/AGU path (port 1); one registered result in flight.
module ysyx_23060286_alu_arb
    import ysyx_23060286_alu_pkg::*;
#(
    parameter int unsigned NPORT    = 2,
    parameter logic        RR_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORT-1:0]      req_valid,
    output logic [NPORT-1:0]      req_ready,
    input  logic [NPORT*32-1:0]   req_srca,
    input  logic [NPORT*32-1:0]   req_srcb,
    input  logic [NPORT*4-1:0]    req_op,
    input  logic [NPORT*3-1:0]    req_f3,
    output logic [NPORT-1:0]      resp_valid,
    input  logic [NPORT-1:0]      resp_ready,
    output logic [31:0]           resp_result,
    output logic                  resp_zero,
    input  logic                  flush
);

    alu_arb_st_e r_state;
    alu_arb_st_e w_state_d;
    logic        r_own;
    // Port preferred on contention; always the complement of the last winner,
    // so RR_RESET=0 means port 0 is served first after reset.
    logic        r_prio;
    logic [31:0] r_result;
    logic        r_zero;

    logic        w_resp_hs;
    logic        w_free;
    logic        w_grant;
    logic        w_win;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [3:0]  w_alu_op;
    logic [2:0]  w_alu_f3;
    logic [31:0] w_alu_res;
    logic        w_alu_zero;

    always_comb begin
        w_resp_hs = (r_state == ST_HOLD) && resp_ready[r_own] && !flush;
        w_free    = (r_state == ST_IDLE) || w_resp_hs;
        w_grant   = w_free && !flush && (|req_valid);

        case (req_valid)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            default: w_win = r_prio;
        endcase

        req_ready = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Operands stay at zero unless a grant is made this cycle.
    always_comb begin
        w_alu_a  = 32'd0;
        w_alu_b  = 32'd0;
        w_alu_op = 4'd0;
        w_alu_f3 = 3'd0;
        if (w_grant) begin
            w_alu_a  = w_win ? req_srca[63:32] : req_srca[31:0];
            w_alu_b  = w_win ? req_srcb[63:32] : req_srcb[31:0];
            w_alu_op = w_win ? req_op[7:4]     : req_op[3:0];
            w_alu_f3 = w_win ? req_f3[5:3]     : req_f3[2:0];
        end
    end

    ysyx_23060286_Alu u_alu (
        .i_srca   (w_alu_a),
        .i_srcb   (w_alu_b),
        .i_op     (w_alu_op),
        .i_f3     (w_alu_f3),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero)
    );

    always_comb begin
        w_state_d = r_state;
        if (flush) begin
            w_state_d = ST_IDLE;
        end else if (w_grant) begin
            w_state_d = ST_HOLD;
        end else if (w_resp_hs) begin
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_own    <= 1'b0;
            r_prio   <= RR_RESET;
            r_result <= 32'd0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_grant) begin
                r_own    <= w_win;
                r_prio   <= ~w_win;
                r_result <= w_alu_res;
                r_zero   <= w_alu_zero;
            end
        end
    end

    always_comb begin
        resp_valid    = '0;
        resp_valid[0] = (r_state == ST_HOLD) && !r_own;
        resp_valid[1] = (r_state == ST_HOLD) && r_own;
        resp_result   = r_result;
        resp_zero     = r_zero;
    end

endmodule
